truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Upstream stimulus stage for the small 3-input gate networks built from AND/OR/NOT cells.
- Drives every input combination onto the gate network in ascending binary order, waits a settle window, and samples the network output into a captured truth table.
- Compares the captured table against an expected table and reports pass/fail plus the lowest failing index.
- Replaces hand-written per-vector testbench sequences with one reusable, clocked sweep block.

Parameters:
- N_IN, 3, number of stimulus bits driven to the network (1..6).
- SETTLE, 2, extra hold cycles per vector before sampling (0..15).
- EXPECTED, 8'h0F, expected truth table, width 2**N_IN; bit i = required output for stim == i.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a sweep; accepted only in IDLE
- dut_out  input  1  output of the network under test
- stim  output  N_IN  vector to the network; MSB = A, then B, then C
- busy  output  1  high from the accepting edge until done is asserted
- done  output  1  one-cycle pulse when the sweep completes
- captured  output  2**N_IN  sampled table; bit i = dut_out observed for stim == i
- pass  output  1  captured == EXPECTED; valid from done, held until next start
- first_fail  output  N_IN  lowest index where captured != EXPECTED; 0 when pass

Behaviour:
- Reset: rst sampled high at an edge forces state=IDLE, stim=0, busy=0, done=0, captured=0, pass=0, first_fail=0, hold counter=0.
  - Reset has priority over start and over any in-progress sweep.
  - A partial sweep is discarded, with no done pulse.
- States:
  - IDLE -> HOLD on start=1 at edge E0. At E0: stim<=0, busy<=1, captured<=0, pass<=0, first_fail<=0.
  - HOLD: stim is held for SETTLE+1 cycles. The hold counter counts 0..SETTLE.
  - On the edge where the counter == SETTLE: captured[stim] <= dut_out and the counter clears.
    - If stim != 2**N_IN-1: stim <= stim+1 and the state stays HOLD.
    - Otherwise: state <= DONE.
  - DONE: lasts one cycle.
    - done=1, busy<=0.
    - pass = (captured == EXPECTED).
    - first_fail = lowest i with captured[i] != EXPECTED[i].
    - stim <= 0; next state IDLE.
- Timing:
  - Vector k is applied at edge E0 + k*(SETTLE+1) and sampled at edge E0 + (k+1)*(SETTLE+1).
  - The sample uses the dut_out value present just before that edge.
  - The last sample is taken at edge E0 + 2**N_IN*(SETTLE+1), where the state moves to DONE.
  - done is high during the cycle after that edge.
  - Defaults: last sample at E0+24, done high in the following cycle.
- start handling:
  - start while busy or in DONE is ignored, with no queuing.
  - start held high continuously gives back-to-back sweeps separated by exactly one IDLE cycle.
- Outputs are registered; no combinational path from dut_out to any output.
- stim wraps only via DONE -> 0, never by counter overflow.
- SETTLE=0 means one cycle per vector.
- captured, pass and first_fail hold their values in IDLE until the next accepted start clears them.
- first_fail is computed from the final captured table, including the last sample.

Optional Feature:
- Macro SWEEP_LOG_EN.
- When defined: at each sample edge the block prints one simulation line with $display in the form "A=%b, B=%b, C=%b out=%b", with one field per stim bit MSB-first. It also prints "PASS" or "FAIL at %d" on done.
- When undefined: no display statements are compiled.
- RTL behaviour and ports are identical in both cases.

Test Plan:
1. Reset, then pulse start with dut_out driven by the !A network model -> done high in the cycle after E0+24, captured=8'h0F, pass=1, first_fail=0, stim back to 0.
2. dut_out tied to 0 -> captured=8'h00, pass=0, first_fail=0.
3. Model faulty only at stim=3'b101 (outputs 1) -> captured=8'h2F, pass=0, first_fail=5.
4. Second start pulse at E0+10 -> ignored; exactly one done pulse, at the cycle after E0+24.
5. rst asserted at E0+12 -> next edge busy=0, stim=0, captured=0, no done; a fresh start then completes normally with pass=1.
6. SETTLE=0 and start held high -> stim steps every cycle, done pulses every 10 cycles (8 samples + DONE + IDLE), each with pass=1.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Clocked exhaustive stimulus sweep for small combinational gate networks.
// Optional macro SWEEP_LOG_EN prints each sampled vector and the final verdict.
module truth_table_sweeper #(
  parameter int                     N_IN     = 3,
  parameter int                     SETTLE   = 2,
  parameter logic [2**N_IN-1:0]     EXPECTED = 8'h0F
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      stim,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   captured,
  output logic                 pass,
  output logic [N_IN-1:0]      first_fail
);
  localparam int TW = 2**N_IN;

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  state_t          state_q;
  logic [N_IN-1:0] stim_q;
  logic [3:0]      cnt_q;
  logic            busy_q, done_q, pass_q;
  logic [TW-1:0]   captured_q;
  logic [N_IN-1:0] first_fail_q;

  logic            sample_en;
  logic            last_vec;
  logic [TW-1:0]   captured_d;
  logic [TW-1:0]   diff;
  logic [N_IN-1:0] first_fail_d;

  assign sample_en = (state_q == HOLD) && (cnt_q == 4'(SETTLE));
  assign last_vec  = (stim_q == {N_IN{1'b1}});

  // Verdict is taken from the table including the sample landing this edge.
  always_comb begin
    captured_d         = captured_q;
    captured_d[stim_q] = dut_out;
    diff               = captured_d ^ EXPECTED;
    first_fail_d       = '0;
    for (int i = TW-1; i >= 0; i--)
      if (diff[i]) first_fail_d = N_IN'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      stim_q       <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      captured_q   <= '0;
      first_fail_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q      <= HOLD;
          stim_q       <= '0;
          cnt_q        <= '0;
          busy_q       <= 1'b1;
          captured_q   <= '0;
          pass_q       <= 1'b0;
          first_fail_q <= '0;
        end
        HOLD: begin
          if (sample_en) begin
            captured_q <= captured_d;
            cnt_q      <= '0;
            if (last_vec) begin
              state_q      <= DONE;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              pass_q       <= (captured_d == EXPECTED);
              first_fail_q <= first_fail_d;
            end else begin
              stim_q <= stim_q + N_IN'(1);
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          stim_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SWEEP_LOG_EN
  always_ff @(posedge clk) begin
    if (!rst && sample_en) begin
      for (int i = N_IN-1; i >= 0; i--) begin
        if (i != N_IN-1) $write(", ");
        $write("%c=%b", 8'(65 + N_IN - 1 - i), stim_q[i]);
      end
      $display(" out=%b", dut_out);
    end
    if (!rst && done_q) begin
      if (pass_q) $display("PASS");
      else        $display("FAIL at %d", first_fail_q);
    end
  end
`endif

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign captured   = captured_q;
  assign pass       = pass_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: default sweeper (SETTLE=2) plus a SETTLE=0 instance for back-to-back sweeps.
module tb_truth_table_sweeper;
  logic       clk = 1'b0;
  logic       rst, start, start0;
  logic [1:0] mode;
  logic [2:0] stim, stim0, first_fail, first_fail0;
  logic [7:0] captured, captured0;
  logic       busy, done, pass, busy0, done0, pass0;
  logic       dut_out, dut_out0;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  // Network models: 0 = !A, 1 = stuck at 0, 2 = !A with a fault at 3'b101.
  function automatic logic net(input logic [2:0] s, input logic [1:0] m);
    case (m)
      2'd0:    return !s[2];
      2'd1:    return 1'b0;
      default: return !s[2] | (s == 3'b101);
    endcase
  endfunction

  assign dut_out  = net(stim, mode);
  assign dut_out0 = net(stim0, 2'd0);

  truth_table_sweeper dut (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out), .stim(stim),
    .busy(busy), .done(done), .captured(captured), .pass(pass),
    .first_fail(first_fail));

  truth_table_sweeper #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .dut_out(dut_out0), .stim(stim0),
    .busy(busy0), .done(done0), .captured(captured0), .pass(pass0),
    .first_fail(first_fail0));

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full sweep from IDLE; optional extra start poked in so it lands at E0+10.
  task automatic sweep(input string tag, input logic [7:0] ecap, input logic epass,
                       input logic [2:0] eff, input bit poke);
    done_cnt = 0;
    start = 1'b1; tick(1); start = 1'b0;        // after E0
    check({tag, ".busy_E0"}, busy, 1);
    check({tag, ".stim_E0"}, stim, 0);
    tick(9);                                     // after E0+9
    check({tag, ".stim_E9"}, stim, 3);
    if (poke) start = 1'b1;
    tick(1); start = 1'b0;                       // after E0+10
    tick(13);                                    // after E0+23
    check({tag, ".done_E23"}, done, 0);
    check({tag, ".busy_E23"}, busy, 1);
    tick(1);                                     // after E0+24
    check({tag, ".done_E24"}, done, 1);
    check({tag, ".busy_E24"}, busy, 0);
    check({tag, ".captured"}, captured, ecap);
    check({tag, ".pass"}, pass, epass);
    check({tag, ".first_fail"}, first_fail, eff);
    tick(1);                                     // after E0+25, IDLE
    check({tag, ".done_E25"}, done, 0);
    check({tag, ".stim_idle"}, stim, 0);
    check({tag, ".done_count"}, done_cnt, 1);
    tick(3);
    check({tag, ".captured_held"}, captured, ecap);
    check({tag, ".pass_held"}, pass, epass);
    check({tag, ".busy_idle"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start0 = 1'b0; mode = 2'd0;
    tick(2);
    rst = 1'b0;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.stim", stim, 0);
    check("rst.captured", captured, 0);
    check("rst.pass", pass, 0);
    check("rst.first_fail", first_fail, 0);

    // 1 + 4: good network, with a stray start in mid-sweep
    sweep("notA", 8'h0F, 1'b1, 3'd0, 1'b1);

    mode = 2'd1;
    sweep("zero", 8'h00, 1'b0, 3'd0, 1'b0);

    mode = 2'd2;
    sweep("fault5", 8'h2F, 1'b0, 3'd5, 1'b0);

    // 5: reset in mid-sweep discards it without a done pulse
    mode = 2'd0; done_cnt = 0;
    start = 1'b1; tick(1); start = 1'b0;         // after E0
    tick(11);                                    // after E0+11
    rst = 1'b1; tick(1); rst = 1'b0;             // after E0+12
    check("midrst.busy", busy, 0);
    check("midrst.stim", stim, 0);
    check("midrst.captured", captured, 0);
    check("midrst.done", done, 0);
    tick(30);
    check("midrst.no_done", done_cnt, 0);
    check("midrst.still_idle", busy, 0);
    sweep("after_rst", 8'h0F, 1'b1, 3'd0, 1'b0);

    // 6: SETTLE=0, start held high -> sweeps every 10 cycles
    start0 = 1'b1; tick(1);                      // after A
    check("s0.stim_A0", stim0, 0);
    check("s0.busy_A0", busy0, 1);
    tick(1);
    check("s0.stim_A1", stim0, 1);
    tick(6);
    check("s0.stim_A7", stim0, 7);
    check("s0.done_A7", done0, 0);
    tick(1);                                     // after A+8
    check("s0.done_A8", done0, 1);
    check("s0.pass_A8", pass0, 1);
    check("s0.cap_A8", captured0, 8'h0F);
    tick(1);
    check("s0.done_A9", done0, 0);
    check("s0.busy_A9", busy0, 0);
    tick(1);
    check("s0.busy_A10", busy0, 1);
    check("s0.stim_A10", stim0, 0);
    tick(7);
    check("s0.done_A17", done0, 0);
    tick(1);
    check("s0.done_A18", done0, 1);
    check("s0.pass_A18", pass0, 1);
    tick(10);
    check("s0.done_A28", done0, 1);
    check("s0.pass_A28", pass0, 1);
    check("s0.ff_A28", first_fail0, 0);
    start0 = 1'b0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
